// File: rtl/check_collision_pkg.sv
// Shared constants and types for the maze collision checker.
//   - dir_e: one-pixel move direction encodings
//   - screen / grid dimensions in pixels and tiles
//   - default tile and sprite sizes
package check_collision_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned GRID_W   = 40;
  localparam int unsigned GRID_H   = 30;
  localparam int unsigned TILES    = GRID_W * GRID_H;

  localparam int unsigned TILE_DEF   = 16;
  localparam int unsigned SPRITE_DEF = 16;

  // Border-only maze: outer ring of tiles is wall, everything else path.
  function automatic logic [TILES-1:0] border_maze();
    logic [TILES-1:0] m;
    m = '0;
    for (int r = 0; r < GRID_H; r++) begin
      for (int c = 0; c < GRID_W; c++) begin
        m[r*GRID_W+c] = (r == 0) || (r == GRID_H - 1) || (c == 0) || (c == GRID_W - 1);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/check_collision_maze_rom.sv
// maze_rom: 1200 x 1-bit tile store (1 = wall), row-major index row*40+col.
// Ports:
//   idx_a, idx_b   : tile indices (11 bits)
//   wall_a, wall_b : combinational wall bits; out-of-range indices read as wall
// MAZE_INIT is accepted for interface compatibility; the built-in border maze is used.
module maze_rom
  import check_collision_pkg::*;
#(
  parameter MAZE_INIT = ""
) (
  input  logic [10:0] idx_a,
  input  logic [10:0] idx_b,
  output logic        wall_a,
  output logic        wall_b
);

  localparam logic [TILES-1:0] Border = border_maze();

  logic [TILES-1:0] tiles;

  assign tiles = Border;

  always_comb begin
    wall_a = 1'b1;
    wall_b = 1'b1;
    if (idx_a < 11'(TILES)) wall_a = tiles[idx_a];
    if (idx_b < 11'(TILES)) wall_b = tiles[idx_b];
  end

endmodule

// File: rtl/clkdiv.sv
// clkdiv: free-running 32-bit up-counter, wraps FFFFFFFF -> 0.
// Ports:
//   clk, rst : clock, synchronous active-high clear
//   clkdiv   : current count
module clkdiv (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] clkdiv
);

  always_ff @(posedge clk) begin
    if (rst) clkdiv <= 32'd0;
    else     clkdiv <= clkdiv + 32'd1;
  end

endmodule

// File: rtl/check_collision.sv
// check_collision: registered "can the object take one more pixel step" test.
// Ports:
//   clk, rst : clock, synchronous active-high reset (result forced to 0)
//   PacX     : object top-left x (0..639)
//   PacY     : object top-left y (0..479)
//   state    : move direction (00 up, 01 down, 10 left, 11 right)
//   result   : 1 = step clear, 0 = blocked; one cycle after the inputs
module check_collision
  import check_collision_pkg::*;
#(
  parameter int unsigned TILE      = TILE_DEF,
  parameter int unsigned SPRITE    = SPRITE_DEF,
  parameter              MAZE_INIT = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] PacX,
  input  logic [8:0] PacY,
  input  logic [1:0] state,
  output logic       result
);

  localparam int unsigned TileShift = $clog2(TILE);
  localparam logic [10:0] Far       = 11'(SPRITE - 1);

  logic [10:0] x, y;
  logic [10:0] px0, px1, py0, py1;
  logic [10:0] idx0, idx1;
  logic        wall0, wall1;
  logic        in_field;
  logic        result_d;

  assign x = {1'b0, PacX};
  assign y = {2'b00, PacY};

  // Two probe pixels on the leading edge after a one-pixel step. A step
  // off the top/left wraps to 2047 at 11 bits, which the range check rejects.
  always_comb begin
    px0 = x;
    px1 = x + Far;
    py0 = y;
    py1 = y + Far;
    unique case (dir_e'(state))
      DIR_UP: begin
        py0 = y - 11'd1;
        py1 = y - 11'd1;
      end
      DIR_DOWN: begin
        py0 = y + 11'(SPRITE);
        py1 = y + 11'(SPRITE);
      end
      DIR_LEFT: begin
        px0 = x - 11'd1;
        px1 = x - 11'd1;
      end
      DIR_RIGHT: begin
        px0 = x + 11'(SPRITE);
        px1 = x + 11'(SPRITE);
      end
    endcase
  end

  // Index arithmetic may wrap for off-field probes; result is masked then.
  assign idx0 = (py0 >> TileShift) * 11'(GRID_W) + (px0 >> TileShift);
  assign idx1 = (py1 >> TileShift) * 11'(GRID_W) + (px1 >> TileShift);

  assign in_field = (px0 < 11'(SCREEN_W)) && (px1 < 11'(SCREEN_W)) &&
                    (py0 < 11'(SCREEN_H)) && (py1 < 11'(SCREEN_H));

  maze_rom #(
    .MAZE_INIT(MAZE_INIT)
  ) u_maze_rom (
    .idx_a (idx0),
    .idx_b (idx1),
    .wall_a(wall0),
    .wall_b(wall1)
  );

  assign result_d = in_field && !wall0 && !wall1;

  always_ff @(posedge clk) begin
    if (rst) result <= 1'b0;
    else     result <= result_d;
  end

endmodule

// File: tb/tb_check_collision.sv
module tb_check_collision;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] PacX;
  logic [8:0] PacY;
  logic [1:0] state;
  logic       result;
  logic       div_rst;
  logic [31:0] cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic  exp;
    string name;
  } exp_t;
  exp_t q[$];

  bit maze [30][40];

  always #5 clk = ~clk;

  check_collision #(
    .TILE(16),
    .SPRITE(16),
    .MAZE_INIT("")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .PacX  (PacX),
    .PacY  (PacY),
    .state (state),
    .result(result)
  );

  clkdiv u_div (
    .clk   (clk),
    .rst   (div_rst),
    .clkdiv(cnt)
  );

  // Reference: list the two probed pixels as signed ints, reject anything
  // off the 640x480 screen, then look up the tile grid.
  function automatic bit model(int x, int y, int s);
    int xs[2];
    int ys[2];
    case (s)
      0: begin xs = '{x, x + 15}; ys = '{y - 1, y - 1}; end
      1: begin xs = '{x, x + 15}; ys = '{y + 16, y + 16}; end
      2: begin xs = '{x - 1, x - 1}; ys = '{y, y + 15}; end
      default: begin xs = '{x + 16, x + 16}; ys = '{y, y + 15}; end
    endcase
    for (int k = 0; k < 2; k++) begin
      if (xs[k] < 0 || xs[k] >= 640 || ys[k] < 0 || ys[k] >= 480) return 1'b0;
      if (maze[ys[k] / 16][xs[k] / 16]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input int x, input int y, input int s, input bit r, input string nm);
    exp_t e;
    @(negedge clk);
    PacX  = 10'(x);
    PacY  = 9'(y);
    state = 2'(s);
    rst   = r;
    e.exp  = r ? 1'b0 : model(x, y, s);
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic chk_cnt(input logic [31:0] exp, input string nm);
    total++;
    if (cnt !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, cnt, exp);
    end
  endtask

  // Monitor: each pushed expectation is due just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (result !== e.exp) begin
          bad++;
          $display("FAIL %s: result=%b want %b (x=%0d y=%0d s=%0d)",
                   e.name, result, e.exp, PacX, PacY, state);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        maze[r][c] = (r == 0 || r == 29 || c == 0 || c == 39);

    rst = 1'b1; PacX = 10'd200; PacY = 9'd100; state = 2'd0; div_rst = 1'b1;

    step(200, 100, 0, 1'b1, "reset0");
    step(200, 100, 0, 1'b1, "reset1");

    step(200, 17, 0, 1'b0, "up_clear");
    step(200, 16, 0, 1'b0, "up_wall");
    step(607, 146, 3, 1'b0, "right_clear");
    step(608, 146, 3, 1'b0, "right_wall");
    step(17, 146, 2, 1'b0, "left_clear");
    step(16, 146, 2, 1'b0, "left_wall");
    step(0, 146, 2, 1'b0, "left_edge");
    step(200, 0, 0, 1'b0, "up_edge");
    step(200, 447, 1, 1'b0, "down_clear");
    step(200, 448, 1, 1'b0, "down_wall");
    step(639, 479, 3, 1'b0, "far_corner");

    for (int i = 0; i < 8; i++) step(200, 16, i % 2, 1'b0, "toggle");

    step(300, 200, 1, 1'b1, "rst_mid");
    step(300, 200, 1, 1'b0, "rst_release");

    for (int i = 0; i < 10000; i++) begin
      int x, y;
      if ($urandom_range(1, 0) == 1) begin
        x = $urandom_range(639, 0);
        y = $urandom_range(479, 0);
      end else begin
        x = ($urandom_range(1, 0) == 1) ? $urandom_range(20, 0) : $urandom_range(639, 600);
        y = ($urandom_range(1, 0) == 1) ? $urandom_range(20, 0) : $urandom_range(479, 440);
      end
      step(x, y, int'($urandom_range(3, 0)), 1'b0, "random");
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    // clkdiv counter
    div_rst = 1'b1;
    @(negedge clk);
    chk_cnt(32'd0, "div_reset");
    div_rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_cnt(32'(i), "div_count");
    end
    div_rst = 1'b1;
    @(negedge clk);
    chk_cnt(32'd0, "div_rst_mid");
    div_rst = 1'b0;
    force u_div.clkdiv = 32'hFFFF_FFFE;
    #1;
    release u_div.clkdiv;
    @(negedge clk);
    chk_cnt(32'hFFFF_FFFF, "div_top");
    @(negedge clk);
    chk_cnt(32'd0, "div_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
